// File: rtl/fpu_mac_issue_if.sv
// Handshake bundle between the issue sequencer, the operand banks, the two
// multiplier inputs and the final adder output of the FPU MAC datapath.
interface fpu_mac_issue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [4*DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]     op_a;
  logic [DATA_W-1:0]     op_b;
  logic [DATA_W-1:0]     op_c;
  logic [DATA_W-1:0]     op_d;
  logic                  stb_a;
  logic                  stb_b;
  logic                  stb_c;
  logic                  stb_d;
  logic                  ack_a;
  logic                  ack_b;
  logic                  ack_c;
  logic                  ack_d;
  logic [DATA_W-1:0]     result;
  logic                  result_stb;
  logic                  result_ack;

  modport master (
    output rd_en, rd_addr, op_a, op_b, op_c, op_d,
           stb_a, stb_b, stb_c, stb_d, result_ack,
    input  rd_data, ack_a, ack_b, ack_c, ack_d, result, result_stb
  );

  modport slave (
    input  rd_en, rd_addr, op_a, op_b, op_c, op_d,
           stb_a, stb_b, stb_c, stb_d, result_ack,
    output rd_data, ack_a, ack_b, ack_c, ack_d, result, result_stb
  );
endinterface

// File: rtl/fpu_mac_issue_sequencer.sv
// Streams {a,b,c,d} operand quadruples from the operand banks into the dual
// multiplier MAC datapath and counts final-adder results up to the programmed length.
module fpu_mac_issue_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              len_err,
  output logic [DATA_W-1:0] last_result,
  output logic [CNT_W-1:0]  issue_cnt,
  output logic [CNT_W-1:0]  res_cnt,
  fpu_mac_issue_if.master   bus
);

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(2 ** ADDR_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     aborted_q, aborted_d;
  logic                     len_err_q, len_err_d;
  logic                     rd_en_q, rd_en_d;
  logic                     result_ack_q, result_ack_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic [3:0][DATA_W-1:0]   op_q, op_d;
  logic [3:0]               stb_q, stb_d;
  logic [CNT_W-1:0]         len_q, len_d;
  logic [CNT_W-1:0]         issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]         res_cnt_q, res_cnt_d;
  logic [DATA_W-1:0]        last_result_q, last_result_d;

  logic [3:0]               ack_s;
  logic [3:0]               pending_s;
  logic                     count_s;
  logic [CNT_W-1:0]         res_cnt_inc_s;
  logic [CNT_W-1:0]         issue_nx_s;

  assign ack_s         = {bus.ack_d, bus.ack_c, bus.ack_b, bus.ack_a};
  assign pending_s     = stb_q & ~ack_s;
  assign count_s       = (state_q != ST_IDLE) && bus.result_stb && result_ack_q;
  // The drain exit compares against this so a result landing in the same cycle counts.
  assign res_cnt_inc_s = (count_s && (res_cnt_q < len_q)) ? (res_cnt_q + CNT_W'(1)) : res_cnt_q;
  assign issue_nx_s    = issue_cnt_q + CNT_W'(1);

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    rd_en_d       = 1'b0;
    result_ack_d  = 1'b1;
    len_err_d     = len_err_q;
    op_d          = op_q;
    stb_d         = stb_q;
    len_d         = len_q;
    issue_cnt_d   = issue_cnt_q;
    res_cnt_d     = res_cnt_q;
    last_result_d = last_result_q;

    if (abort) begin
      state_d = ST_IDLE;
      stb_d   = 4'h0;
      aborted_d = 1'b1;
    end else begin
      if (count_s) begin
        res_cnt_d     = res_cnt_inc_s;
        last_result_d = bus.result;
      end else begin
        res_cnt_d     = res_cnt_q;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (length == {CNT_W{1'b0}}) begin
              done_d = 1'b1;
            end else if (length > DEPTH) begin
              len_err_d = 1'b1;
            end else begin
              len_d       = length;
              len_err_d   = 1'b0;
              issue_cnt_d = {CNT_W{1'b0}};
              res_cnt_d   = {CNT_W{1'b0}};
              rd_en_d     = 1'b1;
              state_d     = ST_FETCH;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_FETCH: state_d = ST_LOAD;
        ST_LOAD: begin
          op_d    = bus.rd_data;
          stb_d   = 4'hF;
          state_d = ST_ISSUE;
        end
        ST_ISSUE: begin
          stb_d = pending_s;
          if (pending_s == 4'h0) begin
            issue_cnt_d = issue_nx_s;
            if (issue_nx_s < len_q) begin
              rd_en_d = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          if (res_cnt_inc_s == len_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    rd_addr_d = issue_cnt_d[ADDR_W-1:0];
    busy_d    = (state_d != ST_IDLE);
  end

  // State and registered-output flops; reset forces every output low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      len_err_q     <= 1'b0;
      rd_en_q       <= 1'b0;
      result_ack_q  <= 1'b0;
      rd_addr_q     <= {ADDR_W{1'b0}};
      op_q          <= {(4*DATA_W){1'b0}};
      stb_q         <= 4'h0;
      len_q         <= {CNT_W{1'b0}};
      issue_cnt_q   <= {CNT_W{1'b0}};
      res_cnt_q     <= {CNT_W{1'b0}};
      last_result_q <= {DATA_W{1'b0}};
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      len_err_q     <= len_err_d;
      rd_en_q       <= rd_en_d;
      result_ack_q  <= result_ack_d;
      rd_addr_q     <= rd_addr_d;
      op_q          <= op_d;
      stb_q         <= stb_d;
      len_q         <= len_d;
      issue_cnt_q   <= issue_cnt_d;
      res_cnt_q     <= res_cnt_d;
      last_result_q <= last_result_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign len_err        = len_err_q;
  assign last_result    = last_result_q;
  assign issue_cnt      = issue_cnt_q;
  assign res_cnt        = res_cnt_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.op_a       = op_q[0];
  assign bus.op_b       = op_q[1];
  assign bus.op_c       = op_q[2];
  assign bus.op_d       = op_q[3];
  assign bus.stb_a      = stb_q[0];
  assign bus.stb_b      = stb_q[1];
  assign bus.stb_c      = stb_q[2];
  assign bus.stb_d      = stb_q[3];
  assign bus.result_ack = result_ack_q;

endmodule

// File: tb/tb_fpu_mac_issue_sequencer.sv
// Randomised bench for fpu_mac_issue_sequencer: a transaction-level model predicts
// every output each cycle, plus directed scenarios with literal expectations.
module tb_fpu_mac_issue_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int CNT_W  = 16;
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_LOAD = 2, PH_ISSUE = 3, PH_DRAIN = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  length = 16'd0;
  logic              busy, done, aborted, len_err;
  logic [DATA_W-1:0] last_result;
  logic [CNT_W-1:0]  issue_cnt, res_cnt;

  fpu_mac_issue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fpu_mac_issue_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .length(length),
    .busy(busy), .done(done), .aborted(aborted), .len_err(len_err),
    .last_result(last_result), .issue_cnt(issue_cnt), .res_cnt(res_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [4*DATA_W-1:0] mem [64];

  // model state
  int                     m_ph;
  int                     m_len;
  logic                   e_busy, e_done, e_aborted, e_len_err, e_rd_en, e_result_ack;
  logic [ADDR_W-1:0]      e_rd_addr;
  logic [3:0][DATA_W-1:0] e_op;
  logic [3:0]             e_stb;
  logic [CNT_W-1:0]       e_issue, e_res_cnt;
  logic [DATA_W-1:0]      e_last;

  // stimulus state
  int          sched[$];
  int          res_lat = 10;
  bit          dly_rand = 1'b0;
  int          dly_cfg[4];
  int          dly0[4];
  int          w[4];
  int          dly[4];
  bit          rd_pend;
  logic [5:0]  rd_pend_addr;
  logic [31:0] last_drv;

  // observation trackers
  int          done_seen, busy_seen;
  int          stb_cycles[4];
  logic [5:0]  addr_log[$];
  bit          opc_moved, opc_hold;
  logic [31:0] opc_prev;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_len = 0;
    e_busy = 1'b0; e_done = 1'b0; e_aborted = 1'b0; e_len_err = 1'b0; e_rd_en = 1'b0;
    e_result_ack = 1'b0; e_rd_addr = '0; e_op = '0; e_stb = 4'h0;
    e_issue = '0; e_res_cnt = '0; e_last = '0;
    sched.delete(); rd_pend = 1'b0;
    for (int x = 0; x < 4; x++) w[x] = 0;
  endtask

  // Advance the model by one clock using the inputs present at that edge.
  task automatic model_step();
    bit counted;
    logic [3:0] ack;
    ack = {bus.ack_d, bus.ack_c, bus.ack_b, bus.ack_a};
    counted = (m_ph != PH_IDLE) && bus.result_stb && e_result_ack;
    e_done = 1'b0; e_aborted = 1'b0; e_rd_en = 1'b0; e_result_ack = 1'b1;
    if (abort) begin
      m_ph = PH_IDLE; e_stb = 4'h0; e_aborted = 1'b1;
    end else begin
      if (counted) begin
        if (e_res_cnt < m_len) e_res_cnt++;
        e_last = bus.result;
      end
      case (m_ph)
        PH_IDLE: if (start) begin
          if (length == 0) e_done = 1'b1;
          else if (length > 64) e_len_err = 1'b1;
          else begin
            m_len = int'(length); e_issue = '0; e_res_cnt = '0; e_len_err = 1'b0;
            m_ph = PH_FETCH; e_rd_en = 1'b1;
          end
        end
        PH_FETCH: m_ph = PH_LOAD;
        PH_LOAD: begin
          e_op = mem[e_issue[5:0]]; e_stb = 4'hF; m_ph = PH_ISSUE;
        end
        PH_ISSUE: begin
          e_stb = e_stb & ~ack;
          if (e_stb == 4'h0) begin
            e_issue++;
            sched.push_back(cyc + res_lat);
            if (e_issue < m_len) begin m_ph = PH_FETCH; e_rd_en = 1'b1; end
            else m_ph = PH_DRAIN;
          end
        end
        PH_DRAIN: if (e_res_cnt == m_len) begin e_done = 1'b1; m_ph = PH_IDLE; end
        default: m_ph = PH_IDLE;
      endcase
    end
    e_busy = (m_ph != PH_IDLE);
    e_rd_addr = e_issue[5:0];
  endtask

  task automatic compare_all();
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("aborted", aborted, e_aborted);
    chk("len_err", len_err, e_len_err);
    chk("rd_en", bus.rd_en, e_rd_en);
    chk("rd_addr", bus.rd_addr, e_rd_addr);
    chk("stb", {bus.stb_d, bus.stb_c, bus.stb_b, bus.stb_a}, e_stb);
    chk("op_a", bus.op_a, e_op[0]);
    chk("op_b", bus.op_b, e_op[1]);
    chk("op_c", bus.op_c, e_op[2]);
    chk("op_d", bus.op_d, e_op[3]);
    chk("issue_cnt", issue_cnt, e_issue);
    chk("res_cnt", res_cnt, e_res_cnt);
    chk("last_result", last_result, e_last);
    chk("result_ack", bus.result_ack, e_result_ack);
  endtask

  task automatic track();
    if (done) done_seen++;
    if (busy) busy_seen++;
    if (bus.stb_a) stb_cycles[0]++;
    if (bus.stb_b) stb_cycles[1]++;
    if (bus.stb_c) stb_cycles[2]++;
    if (bus.stb_d) stb_cycles[3]++;
    if (bus.rd_en) addr_log.push_back(bus.rd_addr);
    if (bus.stb_c && opc_hold && (bus.op_c !== opc_prev)) opc_moved = 1'b1;
    opc_hold = bus.stb_c; opc_prev = bus.op_c;
  endtask

  task automatic clr_track();
    done_seen = 0; busy_seen = 0; addr_log.delete(); opc_moved = 1'b0; opc_hold = 1'b0;
    for (int x = 0; x < 4; x++) stb_cycles[x] = 0;
  endtask

  // Drive the inputs for the cycle that has just begun.
  task automatic drive_next();
    logic [3:0] a;
    for (int x = 0; x < 4; x++) begin
      if (e_stb[x]) begin
        w[x]++;
        if (w[x] == 1)
          dly[x] = (e_issue == 0 && dly0[x] > 0) ? dly0[x]
                   : (dly_rand ? int'($urandom_range(0, 3)) : dly_cfg[x]);
        a[x] = (w[x] > dly[x]);
      end else begin
        w[x] = 0; a[x] = 1'($urandom_range(0, 1));
      end
    end
    {bus.ack_d, bus.ack_c, bus.ack_b, bus.ack_a} = a;
    if (rd_pend) bus.rd_data = mem[rd_pend_addr];
    else bus.rd_data = {$urandom, $urandom, $urandom, $urandom};
    rd_pend = e_rd_en; rd_pend_addr = e_rd_addr;
    while (sched.size() > 0 && sched[0] < cyc) void'(sched.pop_front());
    bus.result = $urandom;
    bus.result_stb = 1'b0;
    if (sched.size() > 0 && sched[0] == cyc) begin
      void'(sched.pop_front()); bus.result_stb = 1'b1; last_drv = bus.result;
    end else if (m_ph == PH_IDLE && $urandom_range(0, 3) == 0) begin
      bus.result_stb = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    cyc++;
    #1;
    compare_all();
    track();
    drive_next();
  endtask

  task automatic launch(input int len);
    length = CNT_W'(len); start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic run_to_idle(input string tag, input int budget);
    int k = 0;
    while (!(m_ph == PH_IDLE && sched.size() == 0) && k < budget) begin tick(); k++; end
    n_tests++;
    if (k >= budget) begin n_fail++; $display("FAIL %s timeout after %0d cycles", tag, k); end
  endtask

  task automatic wait_model(input int ph, input int elem, input int budget, input string tag);
    int k = 0;
    while (!(m_ph == ph && int'(e_issue) == elem) && k < budget) begin tick(); k++; end
    n_tests++;
    if (k >= budget) begin n_fail++; $display("FAIL %s wait expired", tag); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int x = 0; x < 4; x++) begin dly_cfg[x] = 0; dly0[x] = 0; end
    model_reset(); clr_track(); drive_next();
    #2;
    compare_all();
    chk("reset_result_ack", bus.result_ack, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("ack_after_release", bus.result_ack, 1'b1);

    // length 4, acks immediate, results 10 cycles after each issue
    res_lat = 10; clr_track();
    launch(4); run_to_idle("len4", 300);
    chk("len4_addr_count", addr_log.size(), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) chk("len4_addr", addr_log[i], i);
    chk("len4_done_pulses", done_seen, 1);
    chk("len4_issue_cnt", issue_cnt, 4);
    chk("len4_res_cnt", res_cnt, 4);
    chk("len4_last_result", last_result, last_drv);

    // ack_c held off on element 0
    dly0[2] = 5; clr_track();
    launch(2); run_to_idle("ackc", 300);
    dly0[2] = 0;
    chk("ackc_stb_a_cycles", stb_cycles[0], 2);
    chk("ackc_stb_c_cycles", stb_cycles[2], 7);
    chk("ackc_op_c_stable", opc_moved, 1'b0);
    chk("ackc_issue_cnt", issue_cnt, 2);

    // zero and oversized length
    clr_track();
    launch(0);
    chk("len0_done", done, 1'b1);
    chk("len0_busy", busy, 1'b0);
    tick();
    chk("len0_done_drop", done, 1'b0);
    launch(65);
    chk("len65_err", len_err, 1'b1);
    tick(); tick(); tick();
    chk("len65_never_busy", busy_seen, 0);
    launch(1); run_to_idle("len1", 200);
    chk("len_err_cleared", len_err, 1'b0);

    // abort while element 2 is waiting on ack_d
    dly_cfg[3] = 3; clr_track();
    launch(4);
    wait_model(PH_ISSUE, 2, 200, "abort_wait");
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_pulse", aborted, 1'b1);
    chk("abort_stb", {bus.stb_d, bus.stb_c, bus.stb_b, bus.stb_a}, 4'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_issue_cnt", issue_cnt, 2);
    run_to_idle("abort_flush", 100);
    for (int i = 0; i < 10; i++) tick();
    chk("abort_no_done", done_seen, 0);
    dly_cfg[3] = 0;

    // full bank, result coinciding with the last issue ack, start while busy
    res_lat = 3; clr_track();
    launch(64);
    for (int i = 0; i < 20; i++) tick();
    length = 16'd5; start = 1'b1; tick(); start = 1'b0;
    run_to_idle("len64", 600);
    chk("len64_done_pulses", done_seen, 1);
    chk("len64_res_cnt", res_cnt, 64);
    chk("len64_issue_cnt", issue_cnt, 64);

    // asynchronous reset during drain
    res_lat = 20;
    launch(2);
    wait_model(PH_DRAIN, 2, 200, "drain_wait");
    #3; reset_n = 1'b0; #1;
    model_reset();
    compare_all();
    chk("rst_mid_ack", bus.result_ack, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_ack_still_low", bus.result_ack, 1'b0);
    tick();
    chk("rst_ack_back", bus.result_ack, 1'b1);

    // randomised runs
    dly_rand = 1'b1;
    for (int s = 0; s < 30; s++) begin
      int len, abort_at;
      case ($urandom_range(0, 9))
        0: len = 0;
        1: len = int'($urandom_range(65, 300));
        2: len = 64;
        default: len = int'($urandom_range(1, 12));
      endcase
      res_lat = int'($urandom_range(1, 12));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
      launch(len);
      for (int k = 0; k < 3000; k++) begin
        if (m_ph == PH_IDLE && sched.size() == 0) break;
        if (k == abort_at) abort = 1'b1;
        if ($urandom_range(0, 39) == 0) begin
          start = 1'b1; length = CNT_W'($urandom_range(0, 80));
        end
        tick();
        abort = 1'b0; start = 1'b0;
      end
      run_to_idle("random", 50);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/fpu_mac_issue_sequencer.md
# fpu_mac_issue_sequencer

Control block that streams element-wise operand quadruples from the four DMA-loaded operand banks into the dual-multiplier/adder-tree FPU MAC datapath. It reads one quadruple {a,b,c,d} per element, drives the four multiplier input strobe/ack handshakes, and counts final-adder results until the programmed length is complete. It sits between the Avalon register/operand-memory front end and the MAC datapath, replacing ad-hoc strobe sequencing in the slave.

## Interface
- DATA_W, 32, IEEE-754 single operand/result width
- ADDR_W, 6, operand bank address width (bank depth 2^ADDR_W = 64)
- CNT_W, 16, length/counter width
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset; asynchronous, active-low
- start  in  1  launch request, sampled only in IDLE
- abort  in  1  cancel request, any state
- length  in  CNT_W  element count, sampled with start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on completion
- aborted  out  1  one-cycle pulse on abort
- len_err  out  1  sticky: length > 2^ADDR_W; cleared by next accepted start
- rd_en  out  1  operand bank read enable
- rd_addr  out  ADDR_W  operand bank read address
- rd_data  in  4*DATA_W  {d,c,b,a}, valid one cycle after rd_en
- op_a, op_b, op_c, op_d  out  DATA_W each  operand registers to mult0 (a,b) and mult1 (c,d)
- stb_a, stb_b, stb_c, stb_d  out  1 each  operand strobes
- ack_a, ack_b, ack_c, ack_d  in  1 each  multiplier input acks
- result  in  DATA_W  final adder output
- result_stb  in  1  final adder output strobe
- result_ack  out  1  ack to final adder
- last_result  out  DATA_W  most recent counted result
- issue_cnt, res_cnt  out  CNT_W each  elements issued / results counted

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, DRAIN.
- IDLE: start=1, length in 1..2^ADDR_W -> clear counters, len_err=0, latch length, go FETCH. length=0 -> done pulse next cycle, stay IDLE. length>2^ADDR_W -> len_err=1, stay IDLE. start outside IDLE ignored.
- FETCH: rd_en=1, rd_addr=issue_cnt[ADDR_W-1:0]; go LOAD.
- LOAD: latch rd_data into op_a..op_d, set all four stb; go ISSUE.
- ISSUE: each stb_x clears on the cycle after stb_x&ack_x sampled high; op_x held stable while stb_x=1. When last outstanding strobe is acked: issue_cnt+1; go FETCH if issue_cnt+1 < length, else DRAIN.
- DRAIN: wait res_cnt == length -> done pulse, go IDLE.
- Results: result_ack=1 in every state after reset. result_stb&result_ack in FETCH/LOAD/ISSUE/DRAIN -> res_cnt+1 (saturating at length), last_result<=result. In IDLE results are acked but not counted.
- Completion check uses res_cnt including a same-cycle increment.
- abort: highest priority; next cycle state IDLE, all stb=0, rd_en=0, aborted pulse, counters hold values for readout; no done.
- Counters CNT_W bits, unsigned; rd_addr is issue_cnt truncated (no wrap possible since length <= 2^ADDR_W).

## Timing
- Reset values: all outputs 0 (busy, done, aborted, len_err, rd_en, rd_addr, op_*, stb_*, last_result, issue_cnt, res_cnt); result_ack=0 during reset, 1 from first clock after release.
- start accepted at edge T -> busy=1, rd_en=1 in cycle T+1; stb_* high in T+3.
- Minimum per-element issue: 3 cycles (FETCH, LOAD, one ISSUE cycle with all acks high).
- done asserted the cycle after the final counted result_stb edge (state DRAIN), width one cycle; busy low same cycle as done.
- Reset asserted mid-operation: all outputs to reset values immediately (asynchronous).

## Test plan
- length=4, acks tied high, result_stb pulsed 10 cycles after each issue -> rd_addr 0,1,2,3; issue_cnt=4; done one pulse after 4th result; res_cnt=4; last_result = 4th value.
- ack_c delayed 5 cycles on element 0 -> stb_c held 6 cycles, op_c stable, stb_a/b drop after 1 cycle; issue_cnt increments only after ack_c.
- length=0 -> done pulse cycle after start, busy never high; length=65 -> len_err=1, busy stays 0.
- abort in ISSUE with element 2 pending -> next cycle IDLE, stb_*=0, aborted pulse, issue_cnt=2, no done.
- length=64, result_stb arriving in same cycle as final issue ack -> both counted, done after 64th result; start pulsed while busy ignored.
- reset_n low mid-DRAIN -> all outputs 0 asynchronously; result_ack returns to 1 one cycle after release.
